// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory with a req/ready handshake and a
// fixed number of wait states, used to exercise a multicycle core's memory FSM.
// Read data and the error flag are registered on the edge that enters the
// response cycle. A write is committed on the edge that ends its response cycle.
// Misaligned or out-of-range addresses raise MemErr, and such accesses never
// touch the array.
// Build option: define MEM_BYTE_EN_EN to add the ByteEn port, which gives
// per-byte write strobes. Without it, every write updates the full word.
//
// state | meaning
// IDLE  | no request held, ready to accept
// WAIT  | request captured, counting down wait states
// RESP  | response cycle: MemReady pulse, next request may be accepted
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReq,
    input  logic          MemWrite,
    input  logic [AW-1:0] Adr,
    input  logic [31:0]   WriteData,
`ifdef MEM_BYTE_EN_EN
    input  logic [3:0]    ByteEn,
`endif
    output logic [31:0]   ReadData,
    output logic          MemReady,
    output logic          MemErr,
    output logic          Busy
);

    localparam int         IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt;
    logic          wr_q;
    logic [AW-1:0] adr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          sel_wr;
    logic          sel_err;
    logic          fwd;
    logic [AW-1:0] sel_adr;
    logic [31:0]   merged;
    logic [31:0]   rd_word;

    function automatic logic addr_err(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[AW-1:2]} >= AW'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
        return a[IW+1:2];
    endfunction

    // Next-state logic; a request is taken in IDLE or in the response cycle.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    accept  = 1'b1;
                    state_n = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP: begin
                if (MemReq) begin
                    accept  = 1'b1;
                    state_n = (LAT == 4'd0) ? RESP : WAIT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath for the response being entered. With zero latency, that response
    // belongs to the request on the inputs right now. A write that commits on the
    // same edge is forwarded, so a back-to-back read sees the new data.
    always_comb begin
        commit  = (state == RESP) && wr_q && !addr_err(adr_q);
        sel_adr = accept ? Adr : adr_q;
        sel_wr  = accept ? MemWrite : wr_q;
        sel_err = addr_err(sel_adr);
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mem[word_idx(adr_q)][8*k +: 8];
        end
        fwd     = commit && (word_idx(adr_q) == word_idx(sel_adr));
        rd_word = sel_err ? 32'h0 : (fwd ? merged : mem[word_idx(sel_adr)]);
    end

    // State, wait counter, request capture and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= 32'h0;
            be_q     <= 4'hF;
            err_q    <= 1'b0;
            ReadData <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt     <= LAT;
                wr_q    <= MemWrite;
                adr_q   <= Adr;
                wdata_q <= WriteData;
`ifdef MEM_BYTE_EN_EN
                be_q    <= ByteEn;
`else
                be_q    <= 4'hF;
`endif
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            err_q <= (state_n == RESP) ? sel_err : 1'b0;
            if ((state_n == RESP) && !sel_wr) ReadData <= rd_word;
        end
    end

    // Array write at the end of the response cycle; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && commit) mem[word_idx(adr_q)] <= merged;
    end

    assign MemReady = (state == RESP);
    assign Busy     = (state != IDLE);
    assign MemErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Two instances are driven independently, one with
// LATENCY=2 (dut0) and one with LATENCY=0 (dut1). A cycle-numbered transaction
// model predicts every output each cycle, and directed literals pin key results.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int LATS [2] = '{2, 0};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req [2];
    logic        wr  [2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];
    logic [3:0]  be  [2];
    logic [31:0] rd  [2];
    logic        rdy [2];
    logic        er  [2];
    logic        bsy [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .AW(32)) dut0 (
        .clk(clk), .reset(reset), .MemReq(req[0]), .MemWrite(wr[0]),
        .Adr(adr[0]), .WriteData(wd[0]),
`ifdef MEM_BYTE_EN_EN
        .ByteEn(be[0]),
`endif
        .ReadData(rd[0]), .MemReady(rdy[0]), .MemErr(er[0]), .Busy(bsy[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .AW(32)) dut1 (
        .clk(clk), .reset(reset), .MemReq(req[1]), .MemWrite(wr[1]),
        .Adr(adr[1]), .WriteData(wd[1]),
`ifdef MEM_BYTE_EN_EN
        .ByteEn(be[1]),
`endif
        .ReadData(rd[1]), .MemReady(rdy[1]), .MemErr(er[1]), .Busy(bsy[1])
    );

    // ---------------- transaction model ----------------
    logic [31:0] mm [2][DEPTH];
    bit          pend    [2];
    longint      resp_at [2];
    bit          p_wr    [2];
    bit          p_err   [2];
    int          p_idx   [2];
    logic [31:0] p_wd    [2];
    logic [3:0]  p_be    [2];
    logic [31:0] p_rdata [2];
    logic [31:0] e_rd    [2];
    longint      cyc = 0;

    function automatic logic [3:0] eff_be(input logic [3:0] b);
`ifdef MEM_BYTE_EN_EN
        return b;
`else
        return b | 4'hF;
`endif
    endfunction

    // cyc numbers the cycle that starts at each rising edge. A request taken at
    // an edge responds in cycle (cyc after that edge) + LATENCY.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                pend[d] = 0;
                e_rd[d] = 32'h0;
            end else begin
                if (pend[d] && resp_at[d] == cyc) begin
                    if (p_wr[d] && !p_err[d])
                        for (int k = 0; k < 4; k++)
                            if (p_be[d][k]) mm[d][p_idx[d]][8*k +: 8] = p_wd[d][8*k +: 8];
                    pend[d] = 0;
                end
                if (req[d] && !pend[d]) begin
                    p_wr[d]    = wr[d];
                    p_err[d]   = (adr[d] % 4 != 0) || ((adr[d] >> 2) >= DEPTH);
                    p_idx[d]   = p_err[d] ? 0 : int'(adr[d] >> 2);
                    p_wd[d]    = wd[d];
                    p_be[d]    = eff_be(be[d]);
                    p_rdata[d] = p_err[d] ? 32'h0 : mm[d][p_idx[d]];
                    resp_at[d] = cyc + 1 + LATS[d];
                    pend[d]    = 1;
                end
                if (pend[d] && resp_at[d] == cyc + 1 && !p_wr[d]) e_rd[d] = p_rdata[d];
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic ready_x;
            ready_x = pend[d] && (resp_at[d] == cyc);
            chk("MemReady", d, {31'h0, rdy[d]}, {31'h0, ready_x});
            chk("MemErr",   d, {31'h0, er[d]},  {31'h0, ready_x && p_err[d]});
            chk("Busy",     d, {31'h0, bsy[d]}, {31'h0, pend[d]});
            chk("ReadData", d, rd[d], e_rd[d]);
        end
    end

    // ---------------- drivers ----------------
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                        input logic [3:0] b, output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; adr[d] = a; wd[d] = data; be[d] = b;
        @(negedge clk);
        req[d] = 1'b0;
        lat = 1;
        while (!rdy[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = rd[d];
        e = er[d];
        if (!rdy[d]) begin
            n_vec++; n_bad++;
            $display("FAIL timeout dut%0d adr %h: got no MemReady expected one within 40 cycles", d, a);
        end
    endtask

    // Write then read with MemReq held high across the write's response cycle.
    task automatic b2b(input int d, input logic [31:0] aw, input logic [31:0] dw, input logic [31:0] ar,
                       output logic [31:0] r, output int lat);
        int n;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = 1'b1; adr[d] = aw; wd[d] = dw; be[d] = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[d] && n < 40);
        if (!rdy[d]) begin
            n_vec++; n_bad++;
            $display("FAIL timeout b2b write dut%0d: got no MemReady expected one", d);
        end
        wr[d] = 1'b0; adr[d] = ar;
        @(negedge clk);
        req[d] = 1'b0;
        lat = 1;
        while (!rdy[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = rd[d];
        if (!rdy[d]) begin
            n_vec++; n_bad++;
            $display("FAIL timeout b2b read dut%0d: got no MemReady expected one", d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; adr[d] = 32'h0; wd[d] = 32'h0; be[d] = 4'hF;
            pend[d] = 0; e_rd[d] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mm[d][i] = 32'h0;
        end

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata", d, rd[d], 32'h0);
            chk("rst_ready", d, {31'h0, rdy[d]}, 32'h0);
            chk("rst_err",   d, {31'h0, er[d]},  32'h0);
            chk("rst_busy",  d, {31'h0, bsy[d]}, 32'h0);
        end
        reset = 1'b0;

        // Known fill pattern: 0x5A000000 | d<<16 | index
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                xact(d, 1'b1, 32'(i * 4), 32'h5A000000 | 32'(d << 16) | 32'(i), 4'hF, r, e, lat);

        xact(1, 1'b0, 32'h20, 32'h0, 4'hF, r, e, lat);
        chk("fill_rd_dut1_0x20", 1, r, 32'h5A010008);
        chk("lat0_read", 1, 32'(lat), 32'd1);
        xact(0, 1'b0, 32'hFC, 32'h0, 4'hF, r, e, lat);
        chk("last_word_rd", 0, r, 32'h5A00003F);
        chk("last_word_err", 0, {31'h0, e}, 32'h0);

        // LATENCY=2 write then read
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, lat);
        chk("lat2_write", 0, 32'(lat), 32'd3);
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat);
        chk("lat2_read", 0, 32'(lat), 32'd3);
        chk("rd_deadbeef", 0, r, 32'hDEADBEEF);
        chk("rd_deadbeef_err", 0, {31'h0, e}, 32'h0);

        // Misaligned and out-of-range
        xact(0, 1'b0, 32'h13, 32'h0, 4'hF, r, e, lat);
        chk("misalign_err", 0, {31'h0, e}, 32'h1);
        chk("misalign_rd", 0, r, 32'h0);
        xact(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, r, e, lat);
        chk("oor_err", 0, {31'h0, e}, 32'h1);
        chk("oor_rd", 0, r, 32'h0);
        xact(1, 1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 4'hF, r, e, lat);
        chk("oor_wr_err", 1, {31'h0, e}, 32'h1);
        xact(1, 1'b0, 32'h0, 32'h0, 4'hF, r, e, lat);
        chk("no_alias", 1, r, 32'h5A010000);

        // Back-to-back
        b2b(1, 32'h0, 32'h11111111, 32'h0, r, lat);
        chk("b2b_lat0_rd", 1, r, 32'h11111111);
        chk("b2b_lat0_consec", 1, 32'(lat), 32'd1);
        b2b(0, 32'h20, 32'h00000077, 32'h24, r, lat);
        chk("b2b_lat2_rd", 0, r, 32'h5A000009);
        chk("b2b_lat2_lat", 0, 32'(lat), 32'd3);

        // Reset during WAIT aborts a pending write
        xact(0, 1'b1, 32'h8, 32'h00000000, 4'hF, r, e, lat);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h8; wd[0] = 32'hAAAA5555;
        @(negedge clk);
        req[0] = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("abort_busy", 0, {31'h0, bsy[0]}, 32'h0);
        reset = 1'b0;
        xact(0, 1'b0, 32'h8, 32'h0, 4'hF, r, e, lat);
        chk("abort_no_commit", 0, r, 32'h00000000);

`ifdef MEM_BYTE_EN_EN
        xact(1, 1'b1, 32'h4, 32'h12345678, 4'hF, r, e, lat);
        xact(1, 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0101, r, e, lat);
        xact(1, 1'b0, 32'h4, 32'h0, 4'hF, r, e, lat);
        chk("byte_en_0101", 1, r, 32'h12FF56FF);
        xact(1, 1'b1, 32'h4, 32'h00000000, 4'b0000, r, e, lat);
        chk("byte_en_noop_lat", 1, 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h4, 32'h0, 4'hF, r, e, lat);
        chk("byte_en_noop", 1, r, 32'h12FF56FF);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
